// File: rtl/ratio_divider_if.sv
// ratio_divider_if: request/result bundle between a ratio_divider and its requester.
interface ratio_divider_if #(parameter int WIDTH = 32);
  logic start;
  logic signed [WIDTH-1:0] num, den, out;
  logic valid, busy, err, ovf;
  modport master(output start, num, den, input out, valid, busy, err, ovf);
  modport slave(input start, num, den, output out, valid, busy, err, ovf);
endinterface

// File: rtl/ratio_divider.sv
// ratio_divider: fixed-point num/den by restoring division, one quotient bit per cycle, saturating.
// Define DIV_ROUND_EN to round to nearest instead of truncating.
module ratio_divider #(
  parameter int WIDTH = 32,
  parameter int FRAC = 16
) (
  input logic clk,
  input logic reset,
  ratio_divider_if.slave bus
);
  localparam int QW = WIDTH + FRAC;
  localparam int CW = $clog2(QW);
  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] rem, trial;
  logic [QW-1:0] quo, fin;
  logic [WIDTH-1:0] dv;
  logic fail, ge, sat, legal;
  // quo starts as the shifted dividend; its MSB feeds the remainder while quotient bits shift in at the LSB
  always_comb begin
    trial = {rem[WIDTH-1:0], quo[QW-1]};
    ge = trial >= {1'b0, dv};
    legal = !bus.num[WIDTH-1] && |bus.num && !bus.den[WIDTH-1] && |bus.den;
`ifdef DIV_ROUND_EN
    fin = quo + QW'({rem[WIDTH-1:0], 1'b0} >= {1'b0, dv});
`else
    fin = quo;
`endif
    sat = |fin[QW-1:WIDTH-1];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dv <= '0;
      fail <= 1'b0;
      bus.out <= '0;
      bus.valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.err <= 1'b0;
      bus.ovf <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          fail <= !legal;
          dv <= bus.den;
          quo <= {bus.num, {FRAC{1'b0}}};
          rem <= '0;
          cnt <= '0;
          bus.busy <= 1'b1;
          state <= legal ? DIVIDE : DONE;
        end
        DIVIDE: begin
          rem <= ge ? trial - {1'b0, dv} : trial;
          quo <= {quo[QW-2:0], ge};
          cnt <= cnt + 1'b1;
          state <= cnt == CW'(QW - 1) ? DONE : DIVIDE;
        end
        DONE: begin
          bus.out <= fail ? '0 : sat ? {1'b0, {(WIDTH-1){1'b1}}} : fin[WIDTH-1:0];
          bus.err <= fail;
          bus.ovf <= !fail && sat;
          bus.valid <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ratio_divider.sv
// tb_ratio_divider: scoreboard bench for ratio_divider; expectations queued at start, checked on valid.
module tb_ratio_divider;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  typedef struct packed {logic [31:0] o; logic e; logic v;} exp_t;
  exp_t sbq[$];
  ratio_divider_if #(32) bus();
  ratio_divider #(.WIDTH(32), .FRAC(16)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic exp_t mdl(input logic [31:0] n, input logic [31:0] d);
    logic [63:0] dd, q, r;
    exp_t x;
    x = '0;
    if ($signed(n) <= 0 || $signed(d) <= 0) begin
      x.e = 1'b1;
      return x;
    end
    dd = {16'b0, n, 16'b0};
    q = dd / {32'b0, d};
    r = dd % {32'b0, d};
`ifdef DIV_ROUND_EN
    if (2 * r >= {32'b0, d}) q++;
`endif
    x.v = q > 64'h7FFF_FFFF;
    x.o = x.v ? 32'h7FFF_FFFF : q[31:0];
    return x;
  endfunction
  always @(negedge clk) begin
    if (bus.valid) begin
      if (sbq.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        exp_t x;
        x = sbq.pop_front();
        check("result", {bus.out, bus.err, bus.ovf}, {x.o, x.e, x.v});
      end
    end
  end
  // poke: edge at which a second start with other operands is sampled (0 = none)
  task automatic do_op(input string tag, input logic [31:0] n, input logic [31:0] d, input exp_t x,
                       input int lat, input int poke);
    int got_lat = 0;
    int nb = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num = n;
    bus.den = d;
    sbq.push_back(x);
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (k == poke) bus.start = 1'b0;
      if (k == poke - 1) begin
        bus.start = 1'b1;
        bus.num = 32'h0001_0000;
        bus.den = 32'h0003_0000;
      end
      if (bus.valid) begin
        got_lat = k;
        break;
      end
      if (!bus.busy) nb++;
    end
    bus.start = 1'b0;
    check({tag, "_lat"}, got_lat, lat);
    check({tag, "_busy_during"}, nb, 0);
    check({tag, "_busy_done"}, bus.busy, 0);
    repeat (3) @(posedge clk);
    #1 check({tag, "_hold"}, {bus.out, bus.err, bus.ovf, bus.valid}, {x.o, x.e, x.v, 1'b0});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    exp_t x;
    logic [31:0] n, d;
    bus.start = 1'b0;
    bus.num = '0;
    bus.den = '0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", {bus.out, bus.valid, bus.busy, bus.err, bus.ovf}, 0);
    @(negedge clk) reset = 1'b1;
    do_op("three_halves", 32'h0003_0000, 32'h0002_0000, '{32'h0001_8000, 1'b0, 1'b0}, 49, 0);
`ifdef DIV_ROUND_EN
    do_op("two_thirds", 32'h0002_0000, 32'h0003_0000, '{32'h0000_AAAB, 1'b0, 1'b0}, 49, 0);
`else
    do_op("two_thirds", 32'h0002_0000, 32'h0003_0000, '{32'h0000_AAAA, 1'b0, 1'b0}, 49, 0);
`endif
    do_op("den_zero", 32'h0001_0000, 32'h0, '{32'h0, 1'b1, 1'b0}, 1, 0);
    do_op("num_neg", 32'hFFFF_0000, 32'h0001_0000, '{32'h0, 1'b1, 1'b0}, 1, 0);
    do_op("saturate", 32'h7FFF_0000, 32'h1, '{32'h7FFF_FFFF, 1'b0, 1'b1}, 49, 0);
    do_op("restart_ignored", 32'h0003_0000, 32'h0002_0000, '{32'h0001_8000, 1'b0, 1'b0}, 49, 10);
    do_op("start_in_done", 32'h0005_0000, 32'h0002_0000, '{32'h0002_8000, 1'b0, 1'b0}, 49, 49);
    repeat (55) @(posedge clk);
    #1 check("idle_after_ignored", {bus.busy, bus.valid}, 0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.num = 32'h0003_0000;
    bus.den = 32'h0002_0000;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1 check("busy_mid", bus.busy, 1);
    @(posedge clk);
    reset = 1'b0;
    #1 check("reset_mid", {bus.out, bus.valid, bus.busy, bus.err, bus.ovf}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (55) @(posedge clk);
    #1 check("no_valid_after_abort", {bus.busy, bus.valid}, 0);
    do_op("after_reset", 32'h0003_0000, 32'h0002_0000, '{32'h0001_8000, 1'b0, 1'b0}, 49, 0);
    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(32'h7FFF_FFFF, 1);
      d = (i % 2 == 0) ? $urandom_range(32'h7FFF_FFFF, 32'h0000_1000) : $urandom_range(32'hFFFF, 1);
      x = mdl(n, d);
      do_op("random", n, d, x, 49, 0);
    end
    do_op("den_neg", 32'h0001_0000, 32'h8000_0000, mdl(32'h0001_0000, 32'h8000_0000), 1, 0);
    check("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ratio_divider.md
RATIO_DIVIDER -- requirements
Module: ratio_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 The block SHALL have parameter FRAC, default 16, the number of fractional bits (Q(WIDTH-FRAC).FRAC).
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start  input  1  one-cycle request pulse.
REQ-006 The block SHALL have port num  input  WIDTH signed  dividend (e.g. spot price S), fixed point.
REQ-007 The block SHALL have port den  input  WIDTH signed  divisor (e.g. strike K), fixed point.
REQ-008 The block SHALL have port out  output  WIDTH signed registered quotient num/den, fixed point, feeds the ln(x) stage input.
REQ-009 The block SHALL have port valid  output  1  one-cycle pulse marking out as new; drives the ln(x) stage start.
REQ-010 The block SHALL have port busy  output  1  high while a division is in progress.
REQ-011 The block SHALL have port err  output  1  domain error flag (num<=0 or den<=0), qualified by valid.
REQ-012 The block SHALL have port ovf  output  1  saturation flag, qualified by valid.

Function
REQ-013 The block SHALL implement states IDLE, DIVIDE, DONE: IDLE->DIVIDE on start with legal operands; IDLE->DONE on start with illegal operands; DIVIDE->DONE after the last iteration; DONE->IDLE unconditionally.
REQ-014 On the start edge (edge 0) the block SHALL latch num and den, assert busy, and clear an iteration counter.
REQ-015 DIVIDE SHALL perform unsigned restoring division of (num << FRAC) by den, one quotient bit per cycle, MSB first, over exactly WIDTH+FRAC cycles (48 at default parameters, edges 1..48).
REQ-016 The partial remainder SHALL be WIDTH+1 bits wide; the internal quotient SHALL be WIDTH+FRAC bits wide.
REQ-017 In DONE (edge WIDTH+FRAC+1, i.e. 49 at default) out, err, and ovf SHALL be registered, valid SHALL pulse high for exactly one cycle, and busy SHALL deassert.
REQ-018 If the internal quotient exceeds 2^(WIDTH-1)-1, out SHALL be 2^(WIDTH-1)-1 (0x7FFFFFFF) and ovf SHALL be 1; otherwise ovf SHALL be 0.
REQ-019 If num<=0 or den<=0 at start, the block SHALL skip DIVIDE, set out=0 and err=1, and pulse valid on edge 1.
REQ-020 The block SHALL ignore start while busy=1 and leave the operation in progress unaffected.
REQ-021 Start asserted in the DONE cycle SHALL be ignored; the earliest accepted restart SHALL be the cycle after valid.
REQ-022 out, err, and ovf SHALL hold their last values until the next DONE.

Reset
REQ-023 While reset=0, state SHALL be IDLE and out=0, valid=0, busy=0, err=0, ovf=0, with counter, remainder, and quotient cleared, regardless of clk.
REQ-024 Reset asserted mid-DIVIDE SHALL abort the operation with no valid pulse, and after release the block SHALL accept a new start.

Configuration
REQ-025 When macro DIV_ROUND_EN is defined, the block SHALL round to nearest: it SHALL add 1 LSB to the quotient when 2*final_remainder >= den, before the saturation check, with no latency change.
REQ-026 When DIV_ROUND_EN is undefined, the block SHALL truncate the quotient toward zero.

Verification
REQ-027 num=0x00030000, den=0x00020000, start at edge 0 -> valid at edge 49, out=0x00018000, err=0, ovf=0, busy high on edges 1..48.
REQ-028 num=0x00020000, den=0x00030000 -> out=0x0000AAAA without DIV_ROUND_EN and 0x0000AAAB with it.
REQ-029 num=0x00010000, den=0 -> valid at edge 1, out=0, err=1; a second test with num=0xFFFF0000, den=0x00010000 -> same response.
REQ-030 num=0x7FFF0000, den=0x00000001 -> valid at edge 49, out=0x7FFFFFFF, ovf=1.
REQ-031 Start re-pulsed at edge 10 with different operands -> ignored, and the first result is delivered unchanged at edge 49.
REQ-032 reset=0 at edge 20 during DIVIDE -> all outputs 0 immediately and no valid pulse; after release, a new start with 3.0/2.0 -> out=0x00018000 49 edges later.
